cmap_decode_sched: RTL
======================

// Module: cmap_decode_sched
// PURPOSE
//  Tile-level scheduler in front of cmap_decoder. Accepts one command per tile (block count + tag) and
//  forwards cmap words from the cmap fetch stream to the decoder. Computes per-group nz_num by popcount.
//  Limits in-flight blocks to a credit budget and counts decoder output beats. Reports a tile-done pulse
//  with the tile's total non-zero count, which the weight-fetch side uses to size the encoded stream.
// PARAMETERS
//  ZNZ_BITS     16  bits per cmap group (matches decoder)
//  NUM_GROUP    4   groups per cmap word (matches decoder)
//  CNT_W        16  width of block counters / cmd_nblk
//  MAX_OUTST    4   max blocks issued to decoder but not yet retired (>=1)
//  ID_W         4   command tag width
// PORTS
//  clk           in   1                              clock
//  rst           in   1                              asynchronous reset, active high
//  cmd_vld       in   1                              tile command valid
//  cmd_rdy       out  1                              scheduler idle, command accepted on vld&rdy
//  cmd_nblk      in   CNT_W                          number of cmap blocks in tile
//  cmd_id        in   ID_W                           tile tag
//  cmap_vld      in   1                              cmap word valid from fetch
//  cmap_rdy      out  1                              cmap word consumed
//  cmap_data     in   NUM_GROUP*ZNZ_BITS             cmap word, group g = bits [g*ZNZ_BITS +: ZNZ_BITS]
//  dec_znz_vld   out  1                              to decoder znz_vld
//  dec_znz_rdy   in   1                              from decoder znz_rdy
//  dec_znz_din   out  NUM_GROUP*ZNZ_BITS             to decoder znz_din (= cmap_data)
//  dec_nz_num    out  NUM_GROUP*($clog2(ZNZ_BITS)+1) to decoder nz_num, popcount per group
//  dec_out_vld   in   1                              decoder dec_vld (observed)
//  dec_out_rdy   in   1                              sink dec_rdy (observed)
//  done_vld      out  1                              one-cycle tile-complete pulse
//  done_id       out  ID_W                           tag of completed tile, valid with done_vld
//  done_nz_tot   out  CNT_W+$clog2(NUM_GROUP*ZNZ_BITS)+1  total non-zeros in tile, valid with done_vld
//  busy          out  1                              state != IDLE
//  err           out  1                              sticky: retire with zero outstanding
// BEHAVIOUR
//  Reset (async, any time incl. mid-tile)
//  - State IDLE; all counters 0; cmd_rdy=1; cmap_rdy=0; dec_znz_vld=0; done_vld=0; busy=0; err=0.
//  - done_id and done_nz_tot are 0. In-flight blocks are abandoned.
//  FSM: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
//  - IDLE: cmd_rdy=1. On cmd_vld, latch nblk, id; clear issued, retired and nz_tot.
//    Go to DONE if nblk==0, else ISSUE.
//  - ISSUE: credit = (outst < MAX_OUTST). dec_znz_vld = cmap_vld & credit.
//    cmap_rdy = dec_znz_rdy & credit. Data and popcount are combinational pass-through (0 latency).
//    Issue beat = cmap_vld & cmap_rdy. On an issue beat: issued++, outst++, nz_tot += sum of dec_nz_num.
//    When the issue beat makes issued==nblk, go to DRAIN in the next cycle. cmap_rdy is 0 outside ISSUE.
//  - DRAIN: no issue. Go to DONE when retired==nblk (outst==0), evaluated on the updated count.
//    Go directly to DONE in the same cycle the last retire occurs.
//  - DONE: done_vld=1 for exactly one cycle with done_id and done_nz_tot; next state IDLE.
//    Outputs hold their values until the next done.
//  Retire
//  - Retire beat = dec_out_vld & dec_out_rdy. On a retire beat: retired++, outst--.
//  - A retire beat with outst==0 sets err, leaves counters unchanged, and is ignored in any state.
//  - Issue and retire in the same cycle leave outst unchanged; issued and retired both increment.
//  Arithmetic
//  - Counters do not wrap: issued <= nblk, 0 <= outst <= MAX_OUTST.
//  - nz_tot width sized for nblk=2^CNT_W-1 of full words.
//  Command handshake
//  - Commands arriving while busy are stalled by cmd_rdy=0.
//  - Back-to-back tiles: the earliest next accept is the cycle after DONE.
// TESTING
//  1. nblk=3, cmap words 0xFFFF_0000_00FF_0001 x3, sink always ready
//     -> nz_num={16,0,8,1}; done_vld once; done_nz_tot=75; done_id echoes cmd_id.
//  2. nblk=0, id=5 -> no cmap_rdy; done_vld the cycle after accept with id 5, nz_tot 0; cmd_rdy next cycle.
//  3. MAX_OUTST=4, nblk=8, dec_out_rdy=0
//     -> exactly 4 issue beats then cmap_rdy=0 until a retire; each retire frees one issue.
//  4. dec_znz_rdy toggles 1/0, cmap_vld gaps -> beats only on vld&rdy; all 8 words forwarded in order, none duplicated.
//  5. Retire pulse while IDLE -> err=1 and stays 1; counters 0; a following tile completes normally.
//  6. Assert rst after 2 of 5 issues -> next cycle IDLE, busy=0, cmap_rdy=0; a new cmd nblk=1 completes with correct nz_tot.

Source files
------------

// File: rtl/cmap_decode_sched_if.sv
// Bundle of the command, cmap fetch, decoder and completion signals of the
// tile scheduler. The slave modport is the scheduler's own view, and the
// master modport is the view of whatever surrounds it.
interface cmap_decode_sched_if #(
    parameter int ZNZ_BITS  = 16,
    parameter int NUM_GROUP = 4,
    parameter int CNT_W     = 16,
    parameter int ID_W      = 4
);
    localparam int NZ_W  = $clog2(ZNZ_BITS) + 1;
    localparam int TOT_W = CNT_W + $clog2(NUM_GROUP * ZNZ_BITS) + 1;

    logic                        cmd_vld;
    logic                        cmd_rdy;
    logic [CNT_W-1:0]            cmd_nblk;
    logic [ID_W-1:0]             cmd_id;
    logic                        cmap_vld;
    logic                        cmap_rdy;
    logic [NUM_GROUP*ZNZ_BITS-1:0] cmap_data;
    logic                        dec_znz_vld;
    logic                        dec_znz_rdy;
    logic [NUM_GROUP*ZNZ_BITS-1:0] dec_znz_din;
    logic [NUM_GROUP*NZ_W-1:0]   dec_nz_num;
    logic                        dec_out_vld;
    logic                        dec_out_rdy;
    logic                        done_vld;
    logic [ID_W-1:0]             done_id;
    logic [TOT_W-1:0]            done_nz_tot;
    logic                        busy;
    logic                        err;

    modport master (
        output cmd_vld, cmd_nblk, cmd_id, cmap_vld, cmap_data,
               dec_znz_rdy, dec_out_vld, dec_out_rdy,
        input  cmd_rdy, cmap_rdy, dec_znz_vld, dec_znz_din, dec_nz_num,
               done_vld, done_id, done_nz_tot, busy, err
    );

    modport slave (
        input  cmd_vld, cmd_nblk, cmd_id, cmap_vld, cmap_data,
               dec_znz_rdy, dec_out_vld, dec_out_rdy,
        output cmd_rdy, cmap_rdy, dec_znz_vld, dec_znz_din, dec_nz_num,
               done_vld, done_id, done_nz_tot, busy, err
    );
endinterface

// File: rtl/cmap_decode_sched.sv
// Tile-level scheduler in front of the cmap decoder. It takes one command per
// tile and forwards that tile's cmap words to the decoder, with the per-group
// popcount attached. The number of blocks in flight is capped by a credit
// budget, and every decoder output beat retires one block. When the tile is
// finished, the scheduler pulses done with the tile's total non-zero count.
module cmap_decode_sched #(
    parameter int ZNZ_BITS  = 16,
    parameter int NUM_GROUP = 4,
    parameter int CNT_W     = 16,
    parameter int MAX_OUTST = 4,
    parameter int ID_W      = 4
) (
    input logic               clk,
    input logic               rst,
    cmap_decode_sched_if.slave bus
);
    localparam int NZ_W    = $clog2(ZNZ_BITS) + 1;
    localparam int WSUM_W  = $clog2(NUM_GROUP * ZNZ_BITS) + 1;
    localparam int TOT_W   = CNT_W + WSUM_W;
    localparam int OUTST_W = $clog2(MAX_OUTST + 1);

    localparam logic [OUTST_W-1:0] OUTST_LIMIT = OUTST_W'(MAX_OUTST);
    localparam logic [OUTST_W-1:0] OUTST_ONE   = OUTST_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          nblk_q, nblk_d;
    logic [CNT_W-1:0]          issued_q, issued_d;
    logic [CNT_W-1:0]          retired_q, retired_d;
    logic [ID_W-1:0]           id_q, id_d;
    logic [ID_W-1:0]           done_id_q, done_id_d;
    logic [OUTST_W-1:0]        outst_q, outst_d;
    logic [TOT_W-1:0]          nz_tot_q, nz_tot_d;
    logic [TOT_W-1:0]          done_tot_q, done_tot_d;
    logic                      err_q, err_d;

    logic [NUM_GROUP*NZ_W-1:0] nz_num;
    logic [WSUM_W-1:0]         word_sum;
    logic                      credit;
    logic                      issue_beat;
    logic                      retire_beat;
    logic                      retire_ok;

    // Per-group popcount of the incoming cmap word and its sum over the whole word
    always_comb begin
        logic [NZ_W-1:0] cnt;
        cnt      = '0;
        nz_num   = '0;
        word_sum = '0;
        for (int g = 0; g < NUM_GROUP; g++) begin
            cnt = '0;
            for (int b = 0; b < ZNZ_BITS; b++) begin
                cnt = cnt + NZ_W'(bus.cmap_data[g*ZNZ_BITS + b]);
            end
            nz_num[g*NZ_W +: NZ_W] = cnt;
            word_sum = word_sum + WSUM_W'(cnt);
        end
    end

    // Handshake qualifiers: a credit is free while fewer than MAX_OUTST blocks are
    // in flight, and a retire is only legal while something is outstanding
    always_comb begin
        credit      = (outst_q < OUTST_LIMIT);
        issue_beat  = (state_q == S_ISSUE) && credit && bus.cmap_vld && bus.dec_znz_rdy;
        retire_beat = bus.dec_out_vld && bus.dec_out_rdy;
        retire_ok   = retire_beat && (outst_q != '0);
    end

    // Next-state and counter update; transitions look at the post-beat counts
    always_comb begin
        state_d    = state_q;
        nblk_d     = nblk_q;
        id_d       = id_q;
        issued_d   = issued_q;
        retired_d  = retired_q;
        outst_d    = outst_q;
        nz_tot_d   = nz_tot_q;
        done_id_d  = done_id_q;
        done_tot_d = done_tot_q;
        err_d      = err_q | (retire_beat && (outst_q == '0));

        if (issue_beat) begin
            issued_d = issued_q + CNT_ONE;
            nz_tot_d = nz_tot_q + TOT_W'(word_sum);
        end
        if (retire_ok) begin
            retired_d = retired_q + CNT_ONE;
        end
        case ({issue_beat, retire_ok})
            2'b10:   outst_d = outst_q + OUTST_ONE;
            2'b01:   outst_d = outst_q - OUTST_ONE;
            default: outst_d = outst_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_vld) begin
                    nblk_d    = bus.cmd_nblk;
                    id_d      = bus.cmd_id;
                    issued_d  = '0;
                    retired_d = '0;
                    nz_tot_d  = '0;
                    state_d   = (bus.cmd_nblk == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue_beat && (issued_d == nblk_q)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (retired_d == nblk_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            done_id_d  = id_d;
            done_tot_d = nz_tot_d;
        end
    end

    // State and counter registers; reset abandons any tile in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            nblk_q     <= '0;
            id_q       <= '0;
            issued_q   <= '0;
            retired_q  <= '0;
            outst_q    <= '0;
            nz_tot_q   <= '0;
            done_id_q  <= '0;
            done_tot_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            nblk_q     <= nblk_d;
            id_q       <= id_d;
            issued_q   <= issued_d;
            retired_q  <= retired_d;
            outst_q    <= outst_d;
            nz_tot_q   <= nz_tot_d;
            done_id_q  <= done_id_d;
            done_tot_q <= done_tot_d;
            err_q      <= err_d;
        end
    end

    assign bus.cmd_rdy     = (state_q == S_IDLE);
    assign bus.cmap_rdy    = (state_q == S_ISSUE) && bus.dec_znz_rdy && credit;
    assign bus.dec_znz_vld = (state_q == S_ISSUE) && bus.cmap_vld && credit;
    assign bus.dec_znz_din = bus.cmap_data;
    assign bus.dec_nz_num  = nz_num;
    assign bus.done_vld    = (state_q == S_DONE);
    assign bus.done_id     = done_id_q;
    assign bus.done_nz_tot = done_tot_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.err         = err_q;
endmodule
